kernel_run_ctrl: RTL and testbench

Run scheduler placed between the VIO start probe and an HLS kernel plus its `kernel_ram` input buffers in the power-measurement wrapper. It replaces the free-running `ap_start` level with a sequenced series of runs. Each run follows the `ap_ctrl_hs` handshake, then the block steps the dataset index and inserts a fixed idle gap. It also counts the cycles of each run and raises a sticky error if the kernel hangs.

---
 rtl/kernel_ctrl_pkg.sv | 24 ++
 rtl/kernel_run_ctrl_trig_sync.sv | 30 +++
 rtl/kernel_run_ctrl.sv | 136 +++++++++++++
 tb/tb_kernel_run_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_ctrl_pkg.sv
// rtl/kernel_ctrl_pkg.sv - shared state encoding and width helper for the kernel run scheduler
package kernel_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Smallest width that can index v distinct values
  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kernel_run_ctrl_trig_sync.sv
// rtl/kernel_run_ctrl_trig_sync.sv - two-flop synchronizer with rising-edge detect for the VIO trigger
module trig_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic trig_lvl_o,
  output logic trig_rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two metastability stages followed by a delayed copy for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign trig_lvl_o  = sync_q;
  assign trig_rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/kernel_run_ctrl.sv
// rtl/kernel_run_ctrl.sv - sequences ap_ctrl_hs kernel runs with dataset stepping, idle gaps and a watchdog
module kernel_run_ctrl
  import kernel_ctrl_pkg::*;
#(
  parameter int DATASET_NUM = 8,
  parameter int RUN_W       = 16,
  parameter int CYC_W       = 32,
  parameter int GAP_CYCLES  = 16,
  parameter int WD_CYCLES   = 1 << 20,
  parameter int SEL_W       = CLOG2(DATASET_NUM)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             trig_in,
  input  logic [RUN_W-1:0] num_runs,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic [SEL_W-1:0] dataset_sel,
  output logic             ram_swap,
  output logic             busy,
  output logic [RUN_W-1:0] run_cnt,
  output logic [CYC_W-1:0] last_cycles,
  output logic             last_valid,
  output logic             err_timeout
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? CLOG2(GAP_CYCLES) : 1;

  logic             trig_lvl;
  logic             trig_rise;

  state_t           state_q;
  logic             ap_start_q;
  logic [SEL_W-1:0] dataset_sel_q;
  logic             ram_swap_q;
  logic [RUN_W-1:0] run_cnt_q;
  logic [RUN_W-1:0] num_runs_q;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] last_cycles_q;
  logic             last_valid_q;
  logic             err_q;
  logic [GAP_W-1:0] gap_q;

  logic [SEL_W-1:0] sel_next;
  logic             runs_done;

  trig_sync u_trig_sync (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .async_i     (trig_in),
    .trig_lvl_o  (trig_lvl),
    .trig_rise_o (trig_rise)
  );

  assign sel_next  = (dataset_sel_q == SEL_W'(DATASET_NUM - 1)) ? '0 : dataset_sel_q + SEL_W'(1);
  assign runs_done = ((num_runs_q != '0) && (run_cnt_q == num_runs_q)) ||
                     ((num_runs_q == '0) && !trig_lvl);

  // Run sequencer: trigger latch, start handshake, cycle count, watchdog, gap timing
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q       <= IDLE;
      ap_start_q    <= 1'b0;
      dataset_sel_q <= '0;
      ram_swap_q    <= 1'b0;
      run_cnt_q     <= '0;
      num_runs_q    <= '0;
      cyc_q         <= '0;
      last_cycles_q <= '0;
      last_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      gap_q         <= '0;
    end else begin
      ram_swap_q   <= 1'b0;
      last_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig_rise) begin
            num_runs_q    <= num_runs;
            run_cnt_q     <= '0;
            dataset_sel_q <= '0;
            err_q         <= 1'b0;
            state_q       <= ARM;
          end
        end
        ARM: begin
          if (ap_idle) begin
            ap_start_q <= 1'b1;
            cyc_q      <= CYC_W'(1);
            state_q    <= START;
          end
        end
        START, RUN: begin
          if (ap_ready) ap_start_q <= 1'b0;
          if (ap_done) begin
            ap_start_q    <= 1'b0;
            last_cycles_q <= cyc_q;
            last_valid_q  <= 1'b1;
            if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + RUN_W'(1);
            dataset_sel_q <= sel_next;
            ram_swap_q    <= 1'b1;
            gap_q         <= '0;
            state_q       <= GAP;
          end else if (cyc_q >= CYC_W'(WD_CYCLES)) begin
            err_q      <= 1'b1;
            ap_start_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            if (cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
            if ((state_q == START) && ap_ready) state_q <= RUN;
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            state_q <= runs_done ? IDLE : ARM;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ap_start    = ap_start_q;
  assign dataset_sel = dataset_sel_q;
  assign ram_swap    = ram_swap_q;
  assign busy        = (state_q != IDLE);
  assign run_cnt     = run_cnt_q;
  assign last_cycles = last_cycles_q;
  assign last_valid  = last_valid_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
// tb/tb_kernel_run_ctrl.sv - randomized directed bench for kernel_run_ctrl with a behavioural kernel and event log
module tb_kernel_run_ctrl;

  localparam int DN   = 8;
  localparam int GAPC = 16;
  localparam int WD   = 128;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        trig_in = 1'b0;
  logic [15:0] num_runs = '0;
  logic        ap_start;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_idle = 1'b1;
  logic [2:0]  dataset_sel;
  logic        ram_swap;
  logic        busy;
  logic [15:0] run_cnt;
  logic [31:0] last_cycles;
  logic        last_valid;
  logic        err_timeout;

  always #5 ap_clk = ~ap_clk;

  kernel_run_ctrl #(
    .DATASET_NUM (DN),
    .RUN_W       (16),
    .CYC_W       (32),
    .GAP_CYCLES  (GAPC),
    .WD_CYCLES   (WD)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .trig_in     (trig_in),
    .num_runs    (num_runs),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .dataset_sel (dataset_sel),
    .ram_swap    (ram_swap),
    .busy        (busy),
    .run_cnt     (run_cnt),
    .last_cycles (last_cycles),
    .last_valid  (last_valid),
    .err_timeout (err_timeout)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int lat; int rdy; } job_t;
  job_t job_q[$];
  bit   hang = 1'b0;
  bit   idle_block = 1'b0;

  // Kernel model: ready after rdy cycles, done after lat cycles, counted from the first ap_start cycle
  initial begin : kernel_model
    bit   active;
    int   k;
    job_t cur;
    active = 1'b0;
    k = 0;
    cur.lat = 10;
    cur.rdy = 10;
    forever begin
      @(negedge ap_clk);
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (!ap_rst_n) begin
        active = 1'b0;
      end else begin
        if (!active && ap_start && !hang) begin
          active = 1'b1;
          k = 0;
          if (job_q.size() > 0) cur = job_q.pop_front();
          else begin cur.lat = 10; cur.rdy = 10; end
        end
        if (active) begin
          if (k == cur.rdy) ap_ready = 1'b1;
          if (k == cur.lat) begin ap_done = 1'b1; active = 1'b0; end
          k++;
        end
      end
      ap_idle = !active && !idle_block;
    end
  end

  // Event log sampled on the falling edge
  int cyc = 0;
  int start_t[$];
  int width_q[$];
  int gap_q[$];
  int lv_q[$];
  int sel_q[$];
  int swap_t[$];
  int err_t = -1;
  int fall_t = -1;
  logic pst = 1'b0;
  logic perr = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (ap_start && !pst) begin
        if (fall_t >= 0) gap_q.push_back(cyc - fall_t);
        start_t.push_back(cyc);
      end
      if (!ap_start && pst) begin
        if (start_t.size() > 0) width_q.push_back(cyc - start_t[start_t.size()-1]);
        fall_t = cyc;
      end
      if (last_valid) lv_q.push_back(int'(last_cycles));
      if (ram_swap) begin sel_q.push_back(int'(dataset_sel)); swap_t.push_back(cyc); end
      if (err_timeout && !perr) err_t = cyc;
      pst  = ap_start;
      perr = err_timeout;
    end
  end

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    start_t.delete(); width_q.delete(); gap_q.delete();
    lv_q.delete(); sel_q.delete(); swap_t.delete();
    err_t = -1;
    fall_t = -1;
  endtask

  task automatic trig_low();
    trig_in = 1'b0;
    repeat (5) @(negedge ap_clk);
  endtask

  task automatic trigger(input int n, output int lat);
    num_runs = 16'(n);
    @(posedge ap_clk);
    #1 trig_in = 1'b1;
    lat = 0;
    do begin
      @(posedge ap_clk);
      lat++;
      #1;
    end while (!ap_start && lat < 50);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c;
    c = 0;
    while (busy && c < budget) begin
      @(negedge ap_clk);
      c++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (start_t.size() < n && c < budget) begin
      @(negedge ap_clk);
      c++;
    end
    check(tag, start_t.size() >= n, 1);
  endtask

  initial begin : stimulus
    int lat;
    int exp_lat[10];
    int exp_rdy[3];
    job_t j;

    // Reset values
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_run_cnt", run_cnt, 0);
    check("rst_dataset_sel", dataset_sel, 0);
    check("rst_ram_swap", ram_swap, 0);
    check("rst_last_cycles", last_cycles, 0);
    check("rst_last_valid", last_valid, 0);
    check("rst_err", err_timeout, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);

    // Single run, kernel completes 100 cycles after start
    clear_log();
    j.lat = 100; j.rdy = 100; job_q.push_back(j);
    trigger(1, lat);
    check("single_trig_latency", lat, 4);
    wait_idle(400, "single_idle");
    check("single_starts", start_t.size(), 1);
    check("single_last_cycles", qget(lv_q, 0), 101);
    check("single_lv_count", lv_q.size(), 1);
    check("single_run_cnt", run_cnt, 1);
    check("single_dataset_sel", dataset_sel, 1);
    check("single_swaps", sel_q.size(), 1);
    check("single_swap_delay", qget(swap_t, 0) - qget(start_t, 0), 101);
    trig_low();

    // Ten runs with random latency: dataset wrap, gap length, ignored retrigger while busy
    clear_log();
    for (int i = 0; i < 10; i++) begin
      exp_lat[i] = int'($urandom_range(0, 40));
      j.lat = exp_lat[i]; j.rdy = exp_lat[i];
      job_q.push_back(j);
    end
    trigger(10, lat);
    wait_starts(3, 2000, "wrap_reach_run3");
    trig_in = 1'b0;
    repeat (4) @(negedge ap_clk);
    trig_in = 1'b1;
    wait_idle(3000, "wrap_idle");
    check("wrap_lv_count", lv_q.size(), 10);
    check("wrap_run_cnt", run_cnt, 10);
    check("wrap_dataset_sel", dataset_sel, 10 % DN);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap_last_cycles_%0d", i), qget(lv_q, i), exp_lat[i] + 1);
      check($sformatf("wrap_sel_%0d", i), qget(sel_q, i), (i + 1) % DN);
    end
    for (int i = 0; i < 9; i++) begin
      check($sformatf("wrap_gap_%0d", i), qget(gap_q, i), GAPC + 1);
    end
    trig_low();

    // Continuous mode, trigger dropped inside run 3, ready earlier than done
    clear_log();
    for (int i = 0; i < 3; i++) begin
      exp_lat[i] = int'($urandom_range(25, 40));
      exp_rdy[i] = int'($urandom_range(0, exp_lat[i]));
      j.lat = exp_lat[i]; j.rdy = exp_rdy[i];
      job_q.push_back(j);
    end
    trigger(0, lat);
    wait_starts(3, 2000, "cont_reach_run3");
    repeat (10) @(negedge ap_clk);
    trig_in = 1'b0;
    wait_idle(500, "cont_idle");
    check("cont_run_cnt", run_cnt, 3);
    check("cont_starts", start_t.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_last_cycles_%0d", i), qget(lv_q, i), exp_lat[i] + 1);
      check($sformatf("cont_start_width_%0d", i), qget(width_q, i), exp_rdy[i] + 1);
    end
    job_q.delete();
    trig_low();

    // Ready and done on the very first start cycle
    clear_log();
    j.lat = 0; j.rdy = 0; job_q.push_back(j);
    trigger(1, lat);
    wait_idle(200, "same_idle");
    check("same_last_cycles", qget(lv_q, 0), 1);
    check("same_start_width", qget(width_q, 0), 1);
    check("same_swap_delay", qget(swap_t, 0) - qget(start_t, 0), 1);
    check("same_dataset_sel", dataset_sel, 1);
    trig_low();

    // Watchdog: kernel never finishes
    clear_log();
    hang = 1'b1;
    trigger(1, lat);
    wait_idle(400, "wd_idle");
    hang = 1'b0;
    check("wd_err", err_timeout, 1);
    check("wd_err_delay", err_t - qget(start_t, 0), WD);
    check("wd_start_width", qget(width_q, 0), WD);
    check("wd_ap_start", ap_start, 0);
    check("wd_run_cnt", run_cnt, 0);
    check("wd_no_last_valid", lv_q.size(), 0);
    trig_low();
    j.lat = 5; j.rdy = 5; job_q.push_back(j);
    trigger(1, lat);
    check("wd_clear_err", err_timeout, 0);
    wait_idle(200, "wd_retrig_idle");
    check("wd_retrig_run_cnt", run_cnt, 1);
    trig_low();

    // ARM holds off while the kernel reports not idle
    clear_log();
    idle_block = 1'b1;
    num_runs = 16'd1;
    trig_in = 1'b1;
    repeat (20) @(negedge ap_clk);
    check("arm_hold_start", ap_start, 0);
    check("arm_hold_busy", busy, 1);
    idle_block = 1'b0;
    wait_idle(200, "arm_idle");
    check("arm_run_cnt", run_cnt, 1);
    trig_low();

    // Reset in the middle of a run, then retrigger from dataset 0
    clear_log();
    for (int i = 0; i < 5; i++) begin j.lat = 50; j.rdy = 50; job_q.push_back(j); end
    trigger(5, lat);
    wait_starts(2, 1000, "rst_reach_run2");
    repeat (10) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    trig_in = 1'b0;
    @(posedge ap_clk);
    #1;
    check("midrst_ap_start", ap_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_run_cnt", run_cnt, 0);
    check("midrst_dataset_sel", dataset_sel, 0);
    check("midrst_last_cycles", last_cycles, 0);
    check("midrst_err", err_timeout, 0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    job_q.delete();
    repeat (3) @(negedge ap_clk);
    clear_log();
    j.lat = 7; j.rdy = 7; job_q.push_back(j);
    trigger(1, lat);
    check("midrst_retrig_latency", lat, 4);
    wait_idle(200, "midrst_idle");
    check("midrst_first_sel", qget(sel_q, 0), 1);
    check("midrst_last_cycles_run", qget(lv_q, 0), 8);
    trig_low();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
